zsdram_rr_arbiter: RTL and testbench

Parametrised N-channel SDRAM access arbiter that sits between several SDRAM clients (LCD refresh, photon-count capture, host access, and similar) and the single-transaction SDRAM base controller. It accepts independent read or write burst requests per channel and grants them by round-robin, optionally with read priority. It drives one back-end transaction at a time and returns a per-channel one-cycle done pulse with the read burst data. It is the successor to the fixed two-port read/write arbiter: the channel count, burst length and widths are configurable, the arbitration is fair, and the mode is selectable.

---
 rtl/zsdram_rr_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_zsdram_rr_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/zsdram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : zsdram_rr_arbiter
// Description : N-channel SDRAM access arbiter. Picks one client burst
//               request at a time (round-robin, optionally reads first),
//               drives it to the single-transaction SDRAM base controller
//               and returns a one-cycle per-channel done pulse plus the
//               read burst.
//
// Ports
//   clk, rst_n   : system clock, synchronous active-low reset
//   en           : grant enable (an in-flight transaction always completes)
//   iCh_Req/We   : per-channel request level and direction (1 = write)
//   iCh_Addr     : per-channel address, channel c at [c*ADDR_W +: ADDR_W]
//   iCh_Wdata    : per-channel write burst, channel c at [c*BURST*DATA_W +: ...]
//   oCh_Done     : one-hot, one-cycle completion pulse
//   oRd_Data     : read burst, valid while oCh_Done is high
//   oGrant_Id    : channel currently or last served
//   oBusy        : high from grant until the done pulse completes
//   oBe_*        : back-end request ([1] write, [0] read), address, write burst
//   iBe_Done     : back-end completion ([1] write done, [0] read done)
//   iBe_Rdata    : back-end read burst
//
// Revision    : 1.0 - initial release
// ============================================================================
module zsdram_rr_arbiter #(
    parameter int NCH     = 4,
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 16,
    parameter int BURST   = 4,
    parameter int RD_PRIO = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [NCH-1:0]                iCh_Req,
    input  logic [NCH-1:0]                iCh_We,
    input  logic [NCH*ADDR_W-1:0]         iCh_Addr,
    input  logic [NCH*BURST*DATA_W-1:0]   iCh_Wdata,
    output logic [NCH-1:0]                oCh_Done,
    output logic [BURST*DATA_W-1:0]       oRd_Data,
    output logic [2:0]                    oGrant_Id,
    output logic                          oBusy,
    output logic [1:0]                    oBe_Req,
    output logic [ADDR_W-1:0]             oBe_Addr,
    output logic [BURST*DATA_W-1:0]       oBe_Wdata,
    input  logic [1:0]                    iBe_Done,
    input  logic [BURST*DATA_W-1:0]       iBe_Rdata
);

    localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int BW    = BURST * DATA_W;

    localparam logic [PTR_W:0]   c_NCH  = (PTR_W+1)'(NCH);
    localparam logic [PTR_W-1:0] c_LAST = PTR_W'(NCH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Registered state
    state_t             r_state;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_g;
    logic               r_we;
    logic [1:0]         r_be_req;
    logic [ADDR_W-1:0]  r_be_addr;
    logic [BW-1:0]      r_be_wdata;
    logic [NCH-1:0]     r_ch_done;
    logic [BW-1:0]      r_rd_data;
    logic               r_busy;

    // Next-state values
    state_t             w_state_nxt;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic [PTR_W-1:0]   w_g_nxt;
    logic               w_we_nxt;
    logic [1:0]         w_be_req_nxt;
    logic [ADDR_W-1:0]  w_be_addr_nxt;
    logic [BW-1:0]      w_be_wdata_nxt;
    logic [NCH-1:0]     w_ch_done_nxt;
    logic [BW-1:0]      w_rd_data_nxt;
    logic               w_busy_nxt;

    // Arbitration
    logic [NCH-1:0]     w_rd_req;
    logic [NCH-1:0]     w_elig;
    logic               w_found;
    logic [PTR_W-1:0]   w_win;
    logic               w_be_match;

    assign w_rd_req = iCh_Req & ~iCh_We;
    // In read-priority mode writes are only visible when no read is pending.
    assign w_elig   = ((RD_PRIO != 0) && (|w_rd_req)) ? w_rd_req : iCh_Req;

    // Scan from ptr upwards with wrap. The loop runs from the farthest
    // candidate to the nearest so the nearest eligible channel wins.
    always_comb begin : p_pick
        logic [PTR_W:0] w_sum;
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
            if (w_sum >= c_NCH) begin
                w_sum = w_sum - c_NCH;
            end
            if (w_elig[w_sum[PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[PTR_W-1:0];
            end
        end
    end

    // Only the done bit matching the latched direction completes a transfer.
    assign w_be_match = r_we ? iBe_Done[1] : iBe_Done[0];

    always_comb begin : p_next
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_g_nxt        = r_g;
        w_we_nxt       = r_we;
        w_be_req_nxt   = r_be_req;
        w_be_addr_nxt  = r_be_addr;
        w_be_wdata_nxt = r_be_wdata;
        w_ch_done_nxt  = r_ch_done;
        w_rd_data_nxt  = r_rd_data;
        w_busy_nxt     = r_busy;

        case (r_state)
            S_IDLE: begin
                if (en && w_found) begin
                    w_g_nxt        = w_win;
                    w_we_nxt       = iCh_We[w_win];
                    w_be_addr_nxt  = iCh_Addr[int'(w_win)*ADDR_W +: ADDR_W];
                    w_be_wdata_nxt = iCh_Wdata[int'(w_win)*BW +: BW];
                    w_busy_nxt     = 1'b1;
                    w_state_nxt    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_be_match) begin
                    w_be_req_nxt       = 2'b00;
                    w_ch_done_nxt      = '0;
                    w_ch_done_nxt[r_g] = 1'b1;
                    if (!r_we) begin
                        w_rd_data_nxt = iBe_Rdata;
                    end
                    w_state_nxt = S_DONE;
                end else begin
                    w_be_req_nxt = r_we ? 2'b10 : 2'b01;
                end
            end
            S_DONE: begin
                w_ch_done_nxt = '0;
                w_busy_nxt    = 1'b0;
                w_ptr_nxt     = (r_g == c_LAST) ? '0 : r_g + 1'b1;
                w_state_nxt   = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_g        <= '0;
            r_we       <= 1'b0;
            r_be_req   <= 2'b00;
            r_be_addr  <= '0;
            r_be_wdata <= '0;
            r_ch_done  <= '0;
            r_rd_data  <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_g        <= w_g_nxt;
            r_we       <= w_we_nxt;
            r_be_req   <= w_be_req_nxt;
            r_be_addr  <= w_be_addr_nxt;
            r_be_wdata <= w_be_wdata_nxt;
            r_ch_done  <= w_ch_done_nxt;
            r_rd_data  <= w_rd_data_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    assign oCh_Done  = r_ch_done;
    assign oRd_Data  = r_rd_data;
    assign oGrant_Id = 3'(r_g);
    assign oBusy     = r_busy;
    assign oBe_Req   = r_be_req;
    assign oBe_Addr  = r_be_addr;
    assign oBe_Wdata = r_be_wdata;

endmodule
`default_nettype wire

// File: tb/tb_zsdram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_zsdram_rr_arbiter
// Description : Directed self-checking bench for zsdram_rr_arbiter.
//               dut0 runs pure round-robin, dut1 runs with read priority.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zsdram_rr_arbiter;

    localparam int NCH = 4;
    localparam int AW  = 24;
    localparam int DW  = 16;
    localparam int BU  = 4;
    localparam int BW  = BU * DW;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic [NCH-1:0]    req;
    logic [NCH-1:0]    we;
    logic [NCH*AW-1:0] addr;
    logic [NCH*BW-1:0] wdata;
    logic [1:0]        be_done;
    logic [1:0]        pbe_done;
    logic [BW-1:0]     be_rdata;

    logic [NCH-1:0]    ch_done,  p_ch_done;
    logic [BW-1:0]     rd_data,  p_rd_data;
    logic [2:0]        grant,    p_grant;
    logic              busy,     p_busy;
    logic [1:0]        be_req,   p_be_req;
    logic [AW-1:0]     be_addr,  p_be_addr;
    logic [BW-1:0]     be_wdata, p_be_wdata;

    int total = 0;
    int bad   = 0;

    zsdram_rr_arbiter #(.NCH(NCH), .ADDR_W(AW), .DATA_W(DW), .BURST(BU), .RD_PRIO(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .iCh_Req(req), .iCh_We(we), .iCh_Addr(addr), .iCh_Wdata(wdata),
        .oCh_Done(ch_done), .oRd_Data(rd_data), .oGrant_Id(grant), .oBusy(busy),
        .oBe_Req(be_req), .oBe_Addr(be_addr), .oBe_Wdata(be_wdata),
        .iBe_Done(be_done), .iBe_Rdata(be_rdata)
    );

    zsdram_rr_arbiter #(.NCH(NCH), .ADDR_W(AW), .DATA_W(DW), .BURST(BU), .RD_PRIO(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .iCh_Req(req), .iCh_We(we), .iCh_Addr(addr), .iCh_Wdata(wdata),
        .oCh_Done(p_ch_done), .oRd_Data(p_rd_data), .oGrant_Id(p_grant), .oBusy(p_busy),
        .oBe_Req(p_be_req), .oBe_Addr(p_be_addr), .oBe_Wdata(p_be_wdata),
        .iBe_Done(pbe_done), .iBe_Rdata(be_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [BW-1:0] burst_of(input int c);
        logic [BW-1:0] r;
        r = '0;
        for (int k = 0; k < BU; k++) begin
            r[k*DW +: DW] = 16'(32'hA000 + c * 16 + k);
        end
        return r;
    endfunction

    function automatic logic [AW-1:0] addr_of(input int c);
        return 24'(32'h0A0000 + c * 32'h111);
    endfunction

    // Advance one clock edge; outputs are then stable for sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        en       = 1'b1;
        req      = '0;
        we       = '0;
        be_done  = 2'b00;
        pbe_done = 2'b00;
        be_rdata = '0;
        for (int c = 0; c < NCH; c++) begin
            addr[c*AW +: AW]  = addr_of(c);
            wdata[c*BW +: BW] = burst_of(c);
        end
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (be_req !== 2'b00) begin bad++; $display("FAIL rst_be_req got=%b exp=00", be_req); end
        total++; if (be_addr !== '0) begin bad++; $display("FAIL rst_be_addr got=%h exp=0", be_addr); end
        total++; if (be_wdata !== '0) begin bad++; $display("FAIL rst_be_wdata got=%h exp=0", be_wdata); end
        total++; if (ch_done !== 4'b0000) begin bad++; $display("FAIL rst_ch_done got=%b exp=0000", ch_done); end
        total++; if (rd_data !== '0) begin bad++; $display("FAIL rst_rd_data got=%h exp=0", rd_data); end
        total++; if (grant !== 3'd0) begin bad++; $display("FAIL rst_grant got=%0d exp=0", grant); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single_read();
        logic [BW-1:0] exp_rd;
        exp_rd = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        do_reset();
        addr[2*AW +: AW] = 24'h012345;
        req = 4'b0100;
        we  = 4'b0000;
        tick();  // grant edge
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rd_busy got=%b exp=1", busy); end
        total++; if (grant !== 3'd2) begin bad++; $display("FAIL rd_grant got=%0d exp=2", grant); end
        total++; if (be_addr !== 24'h012345) begin bad++; $display("FAIL rd_addr got=%h exp=012345", be_addr); end
        total++; if (be_req !== 2'b00) begin bad++; $display("FAIL rd_req_early got=%b exp=00", be_req); end
        tick();
        total++; if (be_req !== 2'b01) begin bad++; $display("FAIL rd_be_req got=%b exp=01", be_req); end
        be_done  = 2'b01;
        be_rdata = exp_rd;
        tick();  // done sampled
        total++; if (be_req !== 2'b00) begin bad++; $display("FAIL rd_req_drop got=%b exp=00", be_req); end
        total++; if (ch_done !== 4'b0100) begin bad++; $display("FAIL rd_done got=%b exp=0100", ch_done); end
        total++; if (rd_data !== exp_rd) begin bad++; $display("FAIL rd_data got=%h exp=%h", rd_data, exp_rd); end
        be_done  = 2'b00;
        be_rdata = '0;
        req      = '0;
        tick();
        total++; if (ch_done !== 4'b0000) begin bad++; $display("FAIL rd_done_clr got=%b exp=0000", ch_done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rd_busy_fall got=%b exp=0", busy); end
        total++; if (rd_data !== exp_rd) begin bad++; $display("FAIL rd_data_hold got=%h exp=%h", rd_data, exp_rd); end
    endtask

    task automatic test_round_robin();
        int exp_order [5] = '{0, 1, 2, 3, 0};
        int g;
        do_reset();
        req = 4'b1111;
        we  = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            g = exp_order[i];
            tick();  // grant edge
            total++; if (grant !== 3'(g)) begin bad++; $display("FAIL rr_grant[%0d] got=%0d exp=%0d", i, grant, g); end
            total++; if (be_wdata !== burst_of(g)) begin bad++; $display("FAIL rr_wdata[%0d] got=%h exp=%h", i, be_wdata, burst_of(g)); end
            total++; if (be_addr !== addr_of(g)) begin bad++; $display("FAIL rr_addr[%0d] got=%h exp=%h", i, be_addr, addr_of(g)); end
            tick();
            total++; if (be_req !== 2'b10) begin bad++; $display("FAIL rr_be_req[%0d] got=%b exp=10", i, be_req); end
            be_done = 2'b10;
            tick();
            total++; if (ch_done !== 4'(1 << g)) begin bad++; $display("FAIL rr_done[%0d] got=%b exp=%b", i, ch_done, 4'(1 << g)); end
            be_done = 2'b00;
            tick();  // DONE state
        end
        total++; if (rd_data !== '0) begin bad++; $display("FAIL rr_rd_data_kept got=%h exp=0", rd_data); end
        req = '0;
    endtask

    task automatic test_read_priority();
        do_reset();
        req = 4'b1001;
        we  = 4'b0001;  // ch0 write, ch3 read
        tick();
        total++; if (p_grant !== 3'd3) begin bad++; $display("FAIL prio_first got=%0d exp=3", p_grant); end
        tick();
        total++; if (p_be_req !== 2'b01) begin bad++; $display("FAIL prio_be_req got=%b exp=01", p_be_req); end
        pbe_done = 2'b01;
        tick();
        total++; if (p_ch_done !== 4'b1000) begin bad++; $display("FAIL prio_done got=%b exp=1000", p_ch_done); end
        pbe_done = 2'b00;
        req      = 4'b0001;
        tick();  // DONE
        tick();  // grant
        total++; if (p_grant !== 3'd0) begin bad++; $display("FAIL prio_second got=%0d exp=0", p_grant); end
        tick();
        total++; if (p_be_req !== 2'b10) begin bad++; $display("FAIL prio_second_req got=%b exp=10", p_be_req); end
        req = '0;
    endtask

    task automatic test_enable_gating();
        do_reset();
        req = 4'b0010;
        we  = 4'b0000;
        tick();
        total++; if (grant !== 3'd1) begin bad++; $display("FAIL en_grant got=%0d exp=1", grant); end
        en = 1'b0;
        tick();
        total++; if (be_req !== 2'b01) begin bad++; $display("FAIL en_be_req got=%b exp=01", be_req); end
        be_done = 2'b01;
        tick();
        total++; if (ch_done !== 4'b0010) begin bad++; $display("FAIL en_done got=%b exp=0010", ch_done); end
        be_done = 2'b00;
        req     = 4'b1111;
        tick();  // DONE
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (be_req !== 2'b00 || busy !== 1'b0) begin bad++; $display("FAIL en_held[%0d] got req=%b busy=%b exp req=00 busy=0", i, be_req, busy); end
        end
        en = 1'b1;
        tick();
        total++; if (busy !== 1'b1 || grant !== 3'd2) begin bad++; $display("FAIL en_resume got busy=%b grant=%0d exp busy=1 grant=2", busy, grant); end
        tick();
        total++; if (be_req !== 2'b01) begin bad++; $display("FAIL en_resume_req got=%b exp=01", be_req); end
        req = '0;
    endtask

    task automatic test_wrong_done();
        do_reset();
        req = 4'b0001;
        we  = 4'b0001;
        tick();
        tick();
        be_done = 2'b01;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (be_req !== 2'b10 || ch_done !== 4'b0000) begin bad++; $display("FAIL wd_ignore[%0d] got req=%b done=%b exp req=10 done=0000", i, be_req, ch_done); end
        end
        be_done = 2'b10;
        tick();
        total++; if (be_req !== 2'b00 || ch_done !== 4'b0001) begin bad++; $display("FAIL wd_done got req=%b done=%b exp req=00 done=0001", be_req, ch_done); end
        be_done = 2'b00;
        req     = '0;
        tick();
        total++; if (ch_done !== 4'b0000) begin bad++; $display("FAIL wd_single_pulse got=%b exp=0000", ch_done); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        req = 4'b0100;
        we  = 4'b0000;
        tick();
        tick();
        total++; if (be_req !== 2'b01) begin bad++; $display("FAIL mr_pre got=%b exp=01", be_req); end
        rst_n = 1'b0;
        tick();
        total++; if (be_req !== 2'b00 || busy !== 1'b0 || grant !== 3'd0 || ch_done !== 4'b0000 ||
                     be_addr !== '0 || be_wdata !== '0 || rd_data !== '0) begin
            bad++;
            $display("FAIL mr_outputs got req=%b busy=%b grant=%0d done=%b addr=%h exp all zero",
                     be_req, busy, grant, ch_done, be_addr);
        end
        rst_n = 1'b1;
        req   = 4'b1111;
        tick();
        total++; if (grant !== 3'd0 || busy !== 1'b1) begin bad++; $display("FAIL mr_regrant got grant=%0d busy=%b exp grant=0 busy=1", grant, busy); end
        req = '0;
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        req      = '0;
        we       = '0;
        addr     = '0;
        wdata    = '0;
        be_done  = 2'b00;
        pbe_done = 2'b00;
        be_rdata = '0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_read_priority();
        test_enable_gating();
        test_wrong_done();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
